// File: rtl/rggen_rtl_pkg.sv
// rggen_rtl_pkg
// Types and constants shared by the register access controller and its helpers.
//   rggen_access_t : bus access type carried on the 2-bit access fields
//   rggen_status_t : bus response status carried on the 2-bit status fields
//   rggen_state_t  : access controller FSM states
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_READ  = 2'b00,
        RGGEN_WRITE = 2'b01
    } rggen_access_t;

    typedef enum logic [1:0] {
        RGGEN_OKAY   = 2'b00,
        RGGEN_EXOKAY = 2'b01,
        RGGEN_SLVERR = 2'b10,
        RGGEN_DECERR = 2'b11
    } rggen_status_t;

    typedef enum logic [1:0] {
        STATE_IDLE    = 2'b00,
        STATE_BUSY    = 2'b01,
        STATE_RESPOND = 2'b10
    } rggen_state_t;

    // Width of the BUSY-cycle counter: enough to hold TIMEOUT_CYCLES, never zero.
    function automatic int timeout_counter_width(input int timeout_cycles);
        int w;
        w = (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rggen_or_reducer.sv
// rggen_or_reducer
// Masked OR-reduction of N packed WIDTH-bit lanes: lanes whose mask bit is
// clear contribute zero, the remaining lanes are ORed together.
//   i_data   : N lanes, lane k at [WIDTH*k +: WIDTH]
//   i_mask   : per-lane enable
//   o_result : OR of the enabled lanes
module rggen_or_reducer #(
    parameter int WIDTH = 32,
    parameter int N     = 1
) (
    input  logic [WIDTH*N-1:0] i_data,
    input  logic [N-1:0]       i_mask,
    output logic [WIDTH-1:0]   o_result
);

    logic [WIDTH-1:0] masked [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_mask
        assign masked[gi] = i_mask[gi] ? i_data[WIDTH*gi +: WIDTH] : '0;
    end

    always_comb begin
        o_result = '0;
        for (int i = 0; i < N; i++) begin
            o_result = o_result | masked[i];
        end
    end

endmodule

// File: rtl/rggen_register_access_controller.sv
// rggen_register_access_controller
// Accepts one host request at a time, broadcasts it to every register block,
// merges their responses and returns one response to the host. Unmapped
// accesses and (optionally) stalled accesses are terminated with an error so
// the host is never left waiting.
//   i_clk / i_rst            : clock, asynchronous active-high reset
//   i_bus_*  / o_bus_*       : host-side request and response handshakes
//   o_register_*             : latched request broadcast to all register blocks
//   i_register_*             : per-register match, completion, status, read data
module rggen_register_access_controller
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH     = 8,
    parameter int BUS_WIDTH         = 32,
    parameter int REGISTERS         = 1,
    parameter int TIMEOUT_CYCLES    = 0,
    parameter int ERROR_ON_UNMAPPED = 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_bus_valid,
    output logic                           o_bus_ready,
    input  logic [1:0]                     i_bus_access,
    input  logic [ADDRESS_WIDTH-1:0]       i_bus_address,
    input  logic [BUS_WIDTH-1:0]           i_bus_write_data,
    input  logic [BUS_WIDTH-1:0]           i_bus_strobe,
    output logic                           o_bus_response_valid,
    input  logic                           i_bus_response_ready,
    output logic [1:0]                     o_bus_status,
    output logic [BUS_WIDTH-1:0]           o_bus_read_data,
    output logic                           o_register_valid,
    output logic [1:0]                     o_register_access,
    output logic [ADDRESS_WIDTH-1:0]       o_register_address,
    output logic [BUS_WIDTH-1:0]           o_register_write_data,
    output logic [BUS_WIDTH-1:0]           o_register_strobe,
    input  logic [REGISTERS-1:0]           i_register_active,
    input  logic [REGISTERS-1:0]           i_register_ready,
    input  logic [2*REGISTERS-1:0]         i_register_status,
    input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data
);

    localparam int COUNT_WIDTH = timeout_counter_width(TIMEOUT_CYCLES);

    rggen_state_t             state_reg, state_next;
    logic [COUNT_WIDTH-1:0]   count_reg, count_next;
    logic [1:0]               status_reg, status_next;
    logic [BUS_WIDTH-1:0]     read_data_reg, read_data_next;
    logic [1:0]               access_reg;
    logic [ADDRESS_WIDTH-1:0] address_reg;
    logic [BUS_WIDTH-1:0]     write_data_reg;
    logic [BUS_WIDTH-1:0]     strobe_reg;
    logic                     latch_request;

    logic [REGISTERS-1:0]     hit;
    logic [BUS_WIDTH-1:0]     merged_read_data;
    logic [1:0]               merged_status;
    logic                     timeout_hit;

    // Only registers that both matched and completed this cycle contribute.
    assign hit = i_register_active & i_register_ready;

    rggen_or_reducer #(
        .WIDTH (BUS_WIDTH),
        .N     (REGISTERS)
    ) u_read_data_reducer (
        .i_data   (i_register_read_data),
        .i_mask   (hit),
        .o_result (merged_read_data)
    );

    rggen_or_reducer #(
        .WIDTH (2),
        .N     (REGISTERS)
    ) u_status_reducer (
        .i_data   (i_register_status),
        .i_mask   (hit),
        .o_result (merged_status)
    );

    // The counter holds the number of BUSY cycles already elapsed, so the
    // final allowed BUSY cycle is the one where it equals TIMEOUT_CYCLES-1.
    assign timeout_hit = (TIMEOUT_CYCLES > 0) &&
                         (int'(count_reg) == (TIMEOUT_CYCLES - 1));

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        status_next    = status_reg;
        read_data_next = read_data_reg;
        latch_request  = 1'b0;
        case (state_reg)
            STATE_IDLE: begin
                if (i_bus_valid) begin
                    latch_request = 1'b1;
                    state_next    = STATE_BUSY;
                end
            end
            STATE_BUSY: begin
                if (count_reg != '1) begin
                    count_next = count_reg + 1'b1;
                end
                // Completion is checked first so a ready arriving on the
                // timeout cycle still returns the register's own response.
                if (|hit) begin
                    status_next    = merged_status;
                    read_data_next = (access_reg == RGGEN_READ) ? merged_read_data : '0;
                    state_next     = STATE_RESPOND;
                end else if (!(|i_register_active)) begin
                    status_next    = (ERROR_ON_UNMAPPED != 0) ? RGGEN_DECERR : RGGEN_OKAY;
                    read_data_next = '0;
                    state_next     = STATE_RESPOND;
                end else if (timeout_hit) begin
                    status_next    = RGGEN_SLVERR;
                    read_data_next = '0;
                    state_next     = STATE_RESPOND;
                end
            end
            STATE_RESPOND: begin
                if (i_bus_response_ready) begin
                    count_next = '0;
                    state_next = STATE_IDLE;
                end
            end
            default: begin
                state_next = STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg     <= STATE_IDLE;
            count_reg     <= '0;
            status_reg    <= '0;
            read_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            status_reg    <= status_next;
            read_data_reg <= read_data_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            access_reg     <= '0;
            address_reg    <= '0;
            write_data_reg <= '0;
            strobe_reg     <= '0;
        end else if (latch_request) begin
            access_reg     <= i_bus_access;
            address_reg    <= i_bus_address;
            write_data_reg <= i_bus_write_data;
            strobe_reg     <= i_bus_strobe;
        end
    end

    assign o_bus_ready           = (state_reg == STATE_IDLE);
    assign o_register_valid      = (state_reg == STATE_BUSY);
    assign o_bus_response_valid  = (state_reg == STATE_RESPOND);
    assign o_bus_status          = status_reg;
    assign o_bus_read_data       = read_data_reg;
    assign o_register_access     = access_reg;
    assign o_register_address    = address_reg;
    assign o_register_write_data = write_data_reg;
    assign o_register_strobe     = strobe_reg;

endmodule

// File: tb/tb_rggen_register_access_controller.sv
module tb_rggen_register_access_controller;

    localparam int AW  = 8;
    localparam int BW  = 32;
    localparam int NR  = 4;
    localparam int TMO = 4;

    localparam logic [1:0] ACC_READ  = 2'b00;
    localparam logic [1:0] ACC_WRITE = 2'b01;
    localparam logic [1:0] ST_OKAY   = 2'b00;
    localparam logic [1:0] ST_SLVERR = 2'b10;
    localparam logic [1:0] ST_DECERR = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bus_valid = 1'b0;
    logic [1:0] bus_access = '0;
    logic [AW-1:0] bus_address = '0;
    logic [BW-1:0] bus_write_data = '0;
    logic [BW-1:0] bus_strobe = '0;
    logic bus_response_ready = 1'b0;
    logic [NR-1:0] reg_active = '0;
    logic [NR-1:0] reg_ready = '0;
    logic [2*NR-1:0] reg_status = '0;
    logic [BW*NR-1:0] reg_read_data = '0;

    // dut_a: unmapped -> DECERR; dut_b: unmapped -> OKAY. Both time out after 4.
    logic a_ready, a_resp_valid, a_reg_valid;
    logic [1:0] a_status, a_reg_access;
    logic [BW-1:0] a_read_data, a_reg_wd, a_reg_strobe;
    logic [AW-1:0] a_reg_address;
    logic b_ready, b_resp_valid, b_reg_valid;
    logic [1:0] b_status, b_reg_access;
    logic [BW-1:0] b_read_data, b_reg_wd, b_reg_strobe;
    logic [AW-1:0] b_reg_address;

    int total = 0;
    int bad = 0;
    int txn_id = 0;

    always #5 clk = ~clk;

    rggen_register_access_controller #(
        .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .REGISTERS(NR),
        .TIMEOUT_CYCLES(TMO), .ERROR_ON_UNMAPPED(1)
    ) dut_a (
        .i_clk(clk), .i_rst(rst),
        .i_bus_valid(bus_valid), .o_bus_ready(a_ready),
        .i_bus_access(bus_access), .i_bus_address(bus_address),
        .i_bus_write_data(bus_write_data), .i_bus_strobe(bus_strobe),
        .o_bus_response_valid(a_resp_valid), .i_bus_response_ready(bus_response_ready),
        .o_bus_status(a_status), .o_bus_read_data(a_read_data),
        .o_register_valid(a_reg_valid), .o_register_access(a_reg_access),
        .o_register_address(a_reg_address), .o_register_write_data(a_reg_wd),
        .o_register_strobe(a_reg_strobe),
        .i_register_active(reg_active), .i_register_ready(reg_ready),
        .i_register_status(reg_status), .i_register_read_data(reg_read_data)
    );

    rggen_register_access_controller #(
        .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .REGISTERS(NR),
        .TIMEOUT_CYCLES(TMO), .ERROR_ON_UNMAPPED(0)
    ) dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_bus_valid(bus_valid), .o_bus_ready(b_ready),
        .i_bus_access(bus_access), .i_bus_address(bus_address),
        .i_bus_write_data(bus_write_data), .i_bus_strobe(bus_strobe),
        .o_bus_response_valid(b_resp_valid), .i_bus_response_ready(bus_response_ready),
        .o_bus_status(b_status), .o_bus_read_data(b_read_data),
        .o_register_valid(b_reg_valid), .o_register_access(b_reg_access),
        .o_register_address(b_reg_address), .o_register_write_data(b_reg_wd),
        .o_register_strobe(b_reg_strobe),
        .i_register_active(reg_active), .i_register_ready(reg_ready),
        .i_register_status(reg_status), .i_register_read_data(reg_read_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready_a"}, 64'(a_ready), 64'd1);
        chk({tag, "_ready_b"}, 64'(b_ready), 64'd1);
        chk({tag, "_regvalid"}, 64'({a_reg_valid, b_reg_valid}), 64'd0);
        chk({tag, "_respvalid"}, 64'({a_resp_valid, b_resp_valid}), 64'd0);
        chk({tag, "_status"}, 64'({a_status, b_status}), 64'd0);
        chk({tag, "_rdata"}, {a_read_data, b_read_data}, 64'd0);
        chk({tag, "_reqfields"}, 64'({a_reg_access, a_reg_address}), 64'd0);
        chk({tag, "_wd_strobe"}, {a_reg_wd, a_reg_strobe}, 64'd0);
    endtask

    // One complete host transaction. The bench plays all register blocks:
    // every register in act matches, and all of them raise ready dly cycles
    // after the broadcast becomes valid (dly >= TMO means too late).
    task automatic txn(input logic [1:0] acc, input logic [AW-1:0] addr,
                       input logic [BW-1:0] wd, input logic [NR-1:0] act,
                       input int dly, input int hold, input bit rand_regs,
                       input logic [BW-1:0] rd_seed, input logic [1:0] st_seed);
        logic [BW-1:0] rd [NR];
        logic [1:0]    st [NR];
        logic [BW-1:0] or_rd, exp_data, strb;
        logic [1:0]    or_st, exp_sa, exp_sb, held_status;
        logic [BW-1:0] held_data;
        int            exp_lat, cyc;
        bit            seen;

        or_rd = '0;
        or_st = '0;
        strb  = $urandom;
        for (int k = 0; k < NR; k++) begin
            rd[k] = rand_regs ? $urandom : rd_seed;
            st[k] = rand_regs ? 2'($urandom_range(0, 3)) : st_seed;
            if (!act[k]) begin
                rd[k] = '0;
                st[k] = '0;
            end
            or_rd |= rd[k];
            or_st |= st[k];
        end

        // Reference: accept at cycle 0, broadcast from cycle 1, answer the
        // cycle after completion, decode miss, or the last allowed BUSY cycle.
        if (act == '0) begin
            exp_lat = 2;
            exp_sa = ST_DECERR;
            exp_sb = ST_OKAY;
            exp_data = '0;
        end else if (dly < TMO) begin
            exp_lat = 2 + dly;
            exp_sa = or_st;
            exp_sb = or_st;
            exp_data = (acc == ACC_READ) ? or_rd : '0;
        end else begin
            exp_lat = 1 + TMO;
            exp_sa = ST_SLVERR;
            exp_sb = ST_SLVERR;
            exp_data = '0;
        end

        @(negedge clk);
        chk("idle_ready_a", 64'(a_ready), 64'd1);
        chk("idle_ready_b", 64'(b_ready), 64'd1);
        bus_valid = 1'b1;
        bus_access = acc;
        bus_address = addr;
        bus_write_data = wd;
        bus_strobe = strb;

        @(negedge clk);
        bus_valid = 1'b0;
        bus_write_data = $urandom;
        for (int k = 0; k < NR; k++) begin
            reg_read_data[BW*k +: BW] = rd[k];
            reg_status[2*k +: 2] = st[k];
        end
        reg_active = act;
        reg_ready = '0;
        chk("reg_valid", 64'({a_reg_valid, b_reg_valid}), 64'd3);
        chk("reg_ready_low", 64'(a_ready), 64'd0);
        chk("reg_access", 64'(a_reg_access), 64'(acc));
        chk("reg_address", 64'(a_reg_address), 64'(addr));
        chk("reg_write_data", 64'(a_reg_wd), 64'(wd));
        chk("reg_strobe", 64'(a_reg_strobe), 64'(strb));

        seen = 1'b0;
        for (cyc = 1; cyc <= 20; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (a_resp_valid) begin
                seen = 1'b1;
                break;
            end
            reg_ready = ((cyc - 1) >= dly) ? act : '0;
        end
        chk("resp_seen", 64'(a_resp_valid), 64'd1);
        if (seen) chk("latency", 64'(cyc), 64'(exp_lat));
        reg_active = '0;
        reg_ready = '0;
        reg_read_data = '0;
        reg_status = '0;
        chk("resp_valid_b", 64'(b_resp_valid), 64'd1);
        chk("resp_regvalid_low", 64'({a_reg_valid, b_reg_valid}), 64'd0);
        chk("status_a", 64'(a_status), 64'(exp_sa));
        chk("status_b", 64'(b_status), 64'(exp_sb));
        chk("rdata_a", 64'(a_read_data), 64'(exp_data));
        chk("rdata_b", 64'(b_read_data), 64'(exp_data));
        held_status = a_status;
        held_data = a_read_data;

        // Stall the response with a new request pending; it must not be taken.
        for (int h = 0; h < hold; h++) begin
            bus_valid = 1'b1;
            bus_response_ready = 1'b0;
            @(negedge clk);
            chk("hold_valid", 64'(a_resp_valid), 64'd1);
            chk("hold_status", 64'(a_status), 64'(held_status));
            chk("hold_rdata", 64'(a_read_data), 64'(held_data));
            chk("hold_no_accept", 64'({a_ready, b_ready}), 64'd0);
        end
        bus_response_ready = 1'b1;
        @(negedge clk);
        bus_valid = 1'b0;
        bus_response_ready = 1'b0;
        chk("after_hs_valid", 64'({a_resp_valid, b_resp_valid}), 64'd0);
        chk("after_hs_ready", 64'({a_ready, b_ready}), 64'd3);

        $display("txn %0d acc=%0d addr=%02h act=%b dly=%0d hold=%0d lat=%0d status=%0d/%0d data=%08h",
                 txn_id, acc, addr, act, dly, hold, exp_lat, exp_sa, exp_sb, exp_data);
        txn_id++;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Write 0xDEADBEEF to 0x04, register 1 ready two cycles after broadcast.
        txn(ACC_WRITE, 8'h04, 32'hDEADBEEF, 4'b0010, 2, 0, 1'b0, 32'hFFFF_FFFF, ST_OKAY);
        // Read 0x08 from register 2, ready immediately.
        txn(ACC_READ, 8'h08, 32'h0, 4'b0100, 0, 0, 1'b0, 32'h0000_1234, ST_OKAY);
        // Unmapped read.
        txn(ACC_READ, 8'h3C, 32'h0, 4'b0000, 0, 0, 1'b0, 32'h0, ST_OKAY);
        // Matched but never ready: SLVERR after 4 BUSY cycles.
        txn(ACC_READ, 8'h10, 32'h0, 4'b0001, 99, 0, 1'b0, 32'hA5A5_A5A5, ST_OKAY);
        // Ready on the 4th BUSY cycle wins over the timeout.
        txn(ACC_READ, 8'h10, 32'h0, 4'b0001, 3, 0, 1'b0, 32'hA5A5_A5A5, ST_OKAY);
        // Response held for 5 cycles.
        txn(ACC_READ, 8'h0C, 32'h0, 4'b1000, 1, 5, 1'b0, 32'h0BAD_F00D, 2'b01);
        // Two active registers: OR-merged data and status.
        txn(ACC_READ, 8'h20, 32'h0, 4'b0110, 1, 0, 1'b1, 32'h0, ST_OKAY);

        // Reset while BUSY: outputs return to reset values at once, no response.
        @(negedge clk);
        bus_valid = 1'b1;
        bus_access = ACC_READ;
        bus_address = 8'h10;
        @(negedge clk);
        bus_valid = 1'b0;
        reg_active = 4'b0001;
        @(negedge clk);
        chk("pre_rst_busy", 64'(a_reg_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        reg_active = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_noresp", 64'({a_resp_valid, b_resp_valid}), 64'd0);
        end
        txn(ACC_WRITE, 8'h04, 32'h1357_9BDF, 4'b0010, 0, 0, 1'b0, 32'h0, ST_OKAY);

        // Randomized transactions.
        for (int n = 0; n < 40; n++) begin
            logic [NR-1:0] act;
            act = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'(1 << $urandom_range(0, NR - 1));
            if ($urandom_range(0, 7) == 0) act = 4'($urandom);
            txn($urandom_range(0, 1) ? ACC_WRITE : ACC_READ, 8'($urandom), $urandom, act,
                $urandom_range(0, 6), $urandom_range(0, 3), 1'b1, 32'h0, ST_OKAY);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
